// File: rtl/pkt_filter_bp.sv
// ============================================================================
// Module      : pkt_filter_bp
// Description : AXI-Stream packet classifier; routes whole packets to the data
//               path, the control path or drop, with full output backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_filter_bp #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] ETH_TYPE_MATCH       = 16'h0008,
    parameter logic [7:0]  IP_PROTO_MATCH       = 8'h11,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hf2f1,
    parameter bit          DROP_NON_UDP         = 1'b1,
    parameter int          CNT_WIDTH            = 32
) (
    input  logic                                 clk,
    input  logic                                 aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       ctrl_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     ctrl_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      ctrl_m_axis_tuser,
    output logic                                 ctrl_m_axis_tvalid,
    input  logic                                 ctrl_m_axis_tready,
    output logic                                 ctrl_m_axis_tlast,

    output logic [CNT_WIDTH-1:0]                 data_pkt_cnt,
    output logic [CNT_WIDTH-1:0]                 ctrl_pkt_cnt,
    output logic [CNT_WIDTH-1:0]                 drop_pkt_cnt
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_FWD  = 2'd2;

    localparam logic [1:0] c_CL_DATA = 2'd0;
    localparam logic [1:0] c_CL_CTRL = 2'd1;
    localparam logic [1:0] c_CL_DROP = 2'd2;

    localparam logic [1:0] c_CL_NOMATCH = DROP_NON_UDP ? c_CL_DROP : c_CL_DATA;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [1:0]    r_class;
    logic [1:0]    w_class_next;

    logic [DW-1:0] r_hold_data;
    logic [KW-1:0] r_hold_keep;
    logic [UW-1:0] r_hold_user;
    logic          r_hold_last;
    logic          r_hold_valid;

    logic [DW-1:0] r_m_data;
    logic [KW-1:0] r_m_keep;
    logic [UW-1:0] r_m_user;
    logic          r_m_last;
    logic          r_m_valid;

    logic [DW-1:0] r_c_data;
    logic [KW-1:0] r_c_keep;
    logic [UW-1:0] r_c_user;
    logic          r_c_last;
    logic          r_c_valid;

    logic [CNT_WIDTH-1:0] r_data_cnt;
    logic [CNT_WIDTH-1:0] r_ctrl_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    logic w_hdr_ok;
    logic w_m_free;
    logic w_c_free;
    logic w_sel_free;
    logic w_in_hs;
    logic w_move;
    logic w_move_last;
    logic w_load_m;
    logic w_load_c;

    assign w_hdr_ok = (s_axis_tdata[143:128] == ETH_TYPE_MATCH) &&
                      (s_axis_tdata[223:216] == IP_PROTO_MATCH);

    assign w_m_free = !r_m_valid || m_axis_tready;
    assign w_c_free = !r_c_valid || ctrl_m_axis_tready;

    always_comb begin
        w_sel_free = 1'b1;
        case (r_class)
            c_CL_DATA: w_sel_free = w_m_free;
            c_CL_CTRL: w_sel_free = w_c_free;
            default:   w_sel_free = 1'b1;
        endcase
    end

    assign w_in_hs     = s_axis_tvalid && s_axis_tready;
    assign w_move      = (r_state == c_ST_FWD) && r_hold_valid && w_sel_free;
    assign w_move_last = w_move && r_hold_last;
    assign w_load_m    = w_move && (r_class == c_CL_DATA);
    assign w_load_c    = w_move && (r_class == c_CL_CTRL);

    // State register (class travels with the state)
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_ST_IDLE;
            r_class <= c_CL_DATA;
        end else begin
            r_state <= w_state_next;
            r_class <= w_class_next;
        end
    end

    // Next-state and classification
    always_comb begin
        w_state_next = r_state;
        w_class_next = r_class;
        case (r_state)
            c_ST_IDLE: begin
                if (w_in_hs) begin
                    if (s_axis_tlast || !w_hdr_ok) begin
                        w_state_next = c_ST_FWD;
                        w_class_next = c_CL_NOMATCH;
                    end else begin
                        w_state_next = c_ST_HDR;
                    end
                end
            end
            c_ST_HDR: begin
                // Beat 1 is only peeked here; it is accepted later in FWD.
                if (s_axis_tvalid) begin
                    w_state_next = c_ST_FWD;
                    w_class_next = (s_axis_tdata[79:64] == CTRL_UDP_PORT) ? c_CL_CTRL
                                                                           : c_CL_DATA;
                end
            end
            c_ST_FWD: begin
                if (w_move_last) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Input ready; closed on the exit cycle so the next packet starts in IDLE
    always_comb begin
        s_axis_tready = 1'b0;
        case (r_state)
            c_ST_IDLE: s_axis_tready = 1'b1;
            c_ST_HDR:  s_axis_tready = 1'b0;
            c_ST_FWD:  s_axis_tready = w_sel_free && !(r_hold_valid && r_hold_last);
            default:   s_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold_data  <= '0;
            r_hold_keep  <= '0;
            r_hold_user  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
        end else if (w_move_last) begin
            r_hold_valid <= 1'b0;
        end else if (w_in_hs) begin
            r_hold_data  <= s_axis_tdata;
            r_hold_keep  <= s_axis_tkeep;
            r_hold_user  <= s_axis_tuser;
            r_hold_last  <= s_axis_tlast;
            r_hold_valid <= 1'b1;
        end else if (w_move) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Output stages only change when free, so payload stays put under stall
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_user  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_m_free) begin
            r_m_valid <= w_load_m;
            if (w_load_m) begin
                r_m_data <= r_hold_data;
                r_m_keep <= r_hold_keep;
                r_m_user <= r_hold_user;
                r_m_last <= r_hold_last;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_c_data  <= '0;
            r_c_keep  <= '0;
            r_c_user  <= '0;
            r_c_last  <= 1'b0;
            r_c_valid <= 1'b0;
        end else if (w_c_free) begin
            r_c_valid <= w_load_c;
            if (w_load_c) begin
                r_c_data <= r_hold_data;
                r_c_keep <= r_hold_keep;
                r_c_user <= r_hold_user;
                r_c_last <= r_hold_last;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_data_cnt <= '0;
            r_ctrl_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_move_last) begin
            case (r_class)
                c_CL_DATA: r_data_cnt <= r_data_cnt + c_CNT_ONE;
                c_CL_CTRL: r_ctrl_cnt <= r_ctrl_cnt + c_CNT_ONE;
                default:   r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
            endcase
        end
    end

    assign m_axis_tdata       = r_m_data;
    assign m_axis_tkeep       = r_m_keep;
    assign m_axis_tuser       = r_m_user;
    assign m_axis_tlast       = r_m_last;
    assign m_axis_tvalid      = r_m_valid;

    assign ctrl_m_axis_tdata  = r_c_data;
    assign ctrl_m_axis_tkeep  = r_c_keep;
    assign ctrl_m_axis_tuser  = r_c_user;
    assign ctrl_m_axis_tlast  = r_c_last;
    assign ctrl_m_axis_tvalid = r_c_valid;

    assign data_pkt_cnt       = r_data_cnt;
    assign ctrl_pkt_cnt       = r_ctrl_cnt;
    assign drop_pkt_cnt       = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pkt_filter_bp.sv
// ============================================================================
// Module      : tb_pkt_filter_bp
// Description : Directed self-checking bench for pkt_filter_bp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_filter_bp;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tlast;
    logic          sel;

    logic          tr0, tr1;
    logic [DW-1:0] m_d0, c_d0, m_d1, c_d1;
    logic [KW-1:0] m_k0, c_k0, m_k1, c_k1;
    logic [UW-1:0] m_u0, c_u0, m_u1, c_u1;
    logic          m_v0, c_v0, m_v1, c_v1;
    logic          m_l0, c_l0, m_l1, c_l1;
    logic          m_rdy, c_rdy;
    logic [CW-1:0] dcnt0, ccnt0, xcnt0, dcnt1, ccnt1, xcnt1;

    pkt_filter_bp #(.DROP_NON_UDP(1'b1)) u_dut0 (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(tr0), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_d0), .m_axis_tkeep(m_k0), .m_axis_tuser(m_u0),
        .m_axis_tvalid(m_v0), .m_axis_tready(m_rdy), .m_axis_tlast(m_l0),
        .ctrl_m_axis_tdata(c_d0), .ctrl_m_axis_tkeep(c_k0), .ctrl_m_axis_tuser(c_u0),
        .ctrl_m_axis_tvalid(c_v0), .ctrl_m_axis_tready(c_rdy), .ctrl_m_axis_tlast(c_l0),
        .data_pkt_cnt(dcnt0), .ctrl_pkt_cnt(ccnt0), .drop_pkt_cnt(xcnt0)
    );

    pkt_filter_bp #(.DROP_NON_UDP(1'b0)) u_dut1 (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(tr1), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_d1), .m_axis_tkeep(m_k1), .m_axis_tuser(m_u1),
        .m_axis_tvalid(m_v1), .m_axis_tready(1'b1), .m_axis_tlast(m_l1),
        .ctrl_m_axis_tdata(c_d1), .ctrl_m_axis_tkeep(c_k1), .ctrl_m_axis_tuser(c_u1),
        .ctrl_m_axis_tvalid(c_v1), .ctrl_m_axis_tready(1'b1), .ctrl_m_axis_tlast(c_l1),
        .data_pkt_cnt(dcnt1), .ctrl_pkt_cnt(ccnt1), .drop_pkt_cnt(xcnt1)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            cyc;
    } beat_t;

    beat_t mq[$];
    beat_t cq[$];
    beat_t m1q[$];
    int    cyc = 0;
    int    m_vcnt = 0;
    int    c_vcnt = 0;
    int    n_checks = 0;
    int    n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are recorded mid-cycle; they complete on the next rising edge
    always @(negedge clk) begin
        if (m_v0 && m_rdy) mq.push_back('{m_d0, m_k0, m_u0, m_l0, cyc});
        if (c_v0 && c_rdy) cq.push_back('{c_d0, c_k0, c_u0, c_l0, cyc});
        if (m_v1)          m1q.push_back('{m_d1, m_k1, m_u1, m_l1, cyc});
        if (m_v0) m_vcnt <= m_vcnt + 1;
        if (c_v0 || c_v1) c_vcnt <= c_vcnt + 1;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int p, input int b, input logic [15:0] eth,
                                              input logic [7:0] proto, input logic [15:0] port);
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = {p[7:0], b[7:0], 8'(i), 8'ha5};
        if (b == 0) begin
            d[143:128] = eth;
            d[223:216] = proto;
        end
        if (b == 1) d[79:64] = port;
        return d;
    endfunction

    function automatic logic [KW-1:0] mk_keep(input logic last);
        return last ? 32'h0000_ffff : 32'hffff_ffff;
    endfunction

    function automatic logic [UW-1:0] mk_user(input int p, input int b);
        return {96'h0, p[7:0], b[7:0], 16'hbeef};
    endfunction

    // Sends beats 0..n_stop-1 of an n-beat packet, each held until accepted
    task automatic send(input int p, input int n, input int n_stop, input logic [15:0] eth,
                        input logic [7:0] proto, input logic [15:0] port, output int stalls);
        int  t;
        bit  hs;
        stalls = 0;
        for (int b = 0; b < n_stop; b++) begin
            s_tdata  = mk_data(p, b, eth, proto, port);
            s_tkeep  = mk_keep(b == n - 1);
            s_tuser  = mk_user(p, b);
            s_tlast  = (b == n - 1);
            s_tvalid = 1'b1;
            t  = 0;
            hs = 1'b0;
            while (!hs && t < 200) begin
                @(negedge clk);
                hs = sel ? tr1 : tr0;
                @(posedge clk);
                #1;
                if (!hs) begin
                    stalls++;
                    t++;
                end
            end
            if (!hs) check("send_timeout", 0, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic cmp_pkt(input string tag, input int which, input int start, input int p, input int n,
                           input logic [15:0] eth, input logic [7:0] proto, input logic [15:0] port);
        beat_t q[$];
        case (which)
            0:       q = mq;
            1:       q = cq;
            default: q = m1q;
        endcase
        check({tag, "_nbeats"}, q.size() - start, n);
        for (int b = 0; b < n; b++) begin
            if (start + b < q.size())
                check($sformatf("%s_beat%0d", tag, b),
                      {q[start+b].d, q[start+b].k, q[start+b].u, q[start+b].l},
                      {mk_data(p, b, eth, proto, port), mk_keep(b == n - 1), mk_user(p, b), b == n - 1});
        end
    endtask

    task automatic drain();
        repeat (10) @(posedge clk);
        #1;
    endtask

    int st, ms, cs, m1s, mv, cv, t;
    logic [DW+KW+UW+1:0] held;

    initial begin
        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        sel      = 1'b0;
        m_rdy    = 1'b1;
        c_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        check("rst_valids", {m_v0, c_v0, m_v1, c_v1}, 4'b0000);
        check("rst_cnts", {dcnt0, ccnt0, xcnt0}, 96'h0);
        check("rst_tready", tr0, 1'b1);

        // UDP data packet, 3 beats
        ms = mq.size(); cs = cq.size(); cv = c_vcnt;
        send(1, 3, 3, 16'h0008, 8'h11, 16'h1234, st);
        drain();
        cmp_pkt("udp_data", 0, ms, 1, 3, 16'h0008, 8'h11, 16'h1234);
        check("udp_data_cnt", dcnt0, 1);
        check("udp_data_no_ctrl", c_vcnt - cv, 0);

        // UDP control packet, 2 beats
        ms = mq.size(); cs = cq.size(); mv = m_vcnt;
        send(2, 2, 2, 16'h0008, 8'h11, 16'hf2f1, st);
        drain();
        cmp_pkt("udp_ctrl", 1, cs, 2, 2, 16'h0008, 8'h11, 16'hf2f1);
        check("udp_ctrl_cnt", ccnt0, 1);
        check("udp_ctrl_no_data", m_vcnt - mv, 0);

        // IPv6 packet dropped
        mv = m_vcnt; cv = c_vcnt;
        send(3, 4, 4, 16'hdd86, 8'h11, 16'h0000, st);
        drain();
        check("ipv6_drop_stalls", st, 0);
        check("ipv6_drop_no_valid", (m_vcnt - mv) + (c_vcnt - cv), 0);
        check("ipv6_drop_cnt", xcnt0, 1);

        // IPv6 packet forwarded when non-matching traffic is kept
        sel = 1'b1;
        m1s = m1q.size();
        send(4, 4, 4, 16'hdd86, 8'h11, 16'h0000, st);
        drain();
        sel = 1'b0;
        cmp_pkt("ipv6_keep", 2, m1s, 4, 4, 16'hdd86, 8'h11, 16'h0000);
        check("ipv6_keep_cnt", {dcnt1, xcnt1}, {32'd1, 32'd0});

        // Single-beat UDP packet dropped
        mv = m_vcnt;
        send(5, 1, 1, 16'h0008, 8'h11, 16'h0000, st);
        drain();
        check("single_drop_cnt", xcnt0, 2);
        check("single_no_data", m_vcnt - mv, 0);

        // Ctrl packet stalled for 5 cycles, then a data packet
        ms = mq.size(); cs = cq.size();
        fork
            begin
                send(6, 4, 4, 16'h0008, 8'h11, 16'hf2f1, st);
                send(7, 2, 2, 16'h0008, 8'h11, 16'h0077, st);
            end
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!c_v0 && t < 100);
                check("stall_ctrl_seen", c_v0, 1'b1);
                @(posedge clk);
                #1;
                c_rdy = 1'b0;
                @(negedge clk);
                held = {c_v0, c_d0, c_k0, c_u0, c_l0};
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("stall_tready%0d", i), tr0, 1'b0);
                    check($sformatf("stall_hold%0d", i), {c_v0, c_d0, c_k0, c_u0, c_l0}, held);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                c_rdy = 1'b1;
            end
        join
        drain();
        cmp_pkt("stall_ctrl", 1, cs, 6, 4, 16'h0008, 8'h11, 16'hf2f1);
        cmp_pkt("stall_next", 0, ms, 7, 2, 16'h0008, 8'h11, 16'h0077);
        check("stall_order",
              (mq.size() > ms && cq.size() >= cs + 4) ? (mq[ms].cyc > cq[cs+3].cyc) : 1'b0, 1'b1);
        check("stall_cnts", {dcnt0, ccnt0, xcnt0}, {32'd2, 32'd2, 32'd2});

        // Asynchronous reset while beat 2 of a 5-beat packet is presented
        send(8, 5, 2, 16'h0008, 8'h11, 16'h1234, st);
        s_tdata  = mk_data(8, 2, 16'h0008, 8'h11, 16'h1234);
        s_tkeep  = mk_keep(1'b0);
        s_tuser  = mk_user(8, 2);
        s_tvalid = 1'b1;
        @(negedge clk);
        #1;
        aresetn = 1'b0;
        #1;
        check("arst_valids", {m_v0, c_v0}, 2'b00);
        check("arst_cnts", {dcnt0, ccnt0, xcnt0}, 96'h0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        ms = mq.size(); cv = c_vcnt;
        send(9, 3, 3, 16'h0008, 8'h11, 16'h1234, st);
        drain();
        cmp_pkt("post_rst", 0, ms, 9, 3, 16'h0008, 8'h11, 16'h1234);
        check("post_rst_cnts", {dcnt0, ccnt0, xcnt0}, {32'd1, 32'd0, 32'd0});
        check("post_rst_no_ctrl", c_vcnt - cv, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
